apb_master_arbiter: RTL and testbench

Two-requester APB master that shares one APB bus between two internal clients (e.g. a CPU-side port and a DMA/config sequencer) and drives it into APB register slaves. Performs round-robin arbitration, sequences the APB SETUP/ACCESS phases, honours slave wait states via `pready`, and aborts hung transfers with a timeout error. It sits between the requesters and the APB slave fabric (address decode in each slave).

---
 rtl/apb_master_arbiter_if.sv | 51 +++++
 rtl/apb_master_arbiter.sv | 139 +++++++++++++
 tb/tb_apb_master_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bundle of requester, response and APB signals for apb_master_arbiter.
// The "master" modport is the arbiter's view, "slave" is the environment's view
// (the requesters plus the APB slave fabric).
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Requester 0
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    // Requester 1
    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    // Shared response
    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    // APB bus
    logic                  apb_psel;
    logic                  apb_penable;
    logic                  apb_pwrite;
    logic [ADDR_WIDTH-1:0] apb_paddr;
    logic [DATA_WIDTH-1:0] apb_pwdata;
    logic [DATA_WIDTH-1:0] apb_prdata;
    logic                  apb_pready;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_prdata, apb_pready
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_prdata, apb_pready
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// pready wait states and an optional ACCESS-phase timeout. All outputs except
// the two request-ready strobes are registered.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input logic                  clk,
    input logic                  rst,
    apb_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter holds 0..TIMEOUT; a disabled timeout still needs one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the counter during the TIMEOUT-th ACCESS cycle (first ACCESS = 0).
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                state_q;
    logic                  grant_q;       // owner of the transfer in flight
    logic                  last_grant_q;  // most recent winner, for round-robin
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic ready0;
    logic ready1;

    // Round-robin acceptance: on a tie the requester that did not win last time goes.
    always_comb begin
        // NOTE: default every output first so no path through the block can infer a latch.
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            ready0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
            ready1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        end
    end

    // Saturating ACCESS-cycle count, so a disabled timeout can never wrap.
    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Transfer FSM with all APB and response outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready0 || ready1) begin
                        grant_q      <= ready1;
                        last_grant_q <= ready1;
                        pwrite_q     <= ready1 ? bus.req1_write : bus.req0_write;
                        paddr_q      <= ready1 ? bus.req1_addr  : bus.req0_addr;
                        pwdata_q     <= ready1 ? bus.req1_wdata : bus.req0_wdata;
                        psel_q       <= 1'b1;
                        penable_q    <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.apb_pready) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp0_valid_q <= !grant_q;
                        rsp1_valid_q <= grant_q;
                        rsp_rdata_q  <= pwrite_q ? '0 : bus.apb_prdata;
                        rsp_err_q    <= 1'b0;
                        state_q      <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        rsp0_valid_q <= !grant_q;
                        rsp1_valid_q <= grant_q;
                        rsp_rdata_q  <= '0;
                        rsp_err_q    <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pwdata  = pwdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized bench for apb_master_arbiter: two requesters, a wait-stating APB
// register slave, a transaction-level reference model and a scoreboard.
module tb_apb_master_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            id;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            acc;    // acceptance cycle
        int            due;    // cycle the response must appear
        logic          err;
        logic [DW-1:0] rdata;
    } xfer_t;

    xfer_t         sb[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            cyc = 0;
    int            vprob = 70;
    bit            drive_en = 1'b0;
    int            req_wait[2];     // slave wait states attached to each pending request
    int            slave_wait = 0;  // wait states for the transfer currently on the bus
    logic [DW-1:0] model_mem[256];
    logic [DW-1:0] slave_mem[256];
    logic          rst_at_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Tracks whether the DUT saw reset at the most recent clock edge.
    always @(posedge clk) rst_at_edge <= rst;

    // Requester driver: hold each request until the handshake, then issue a fresh one.
    initial begin
        bit            v[2];
        bit            took[2];
        logic          wr[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2];
        xfer_t         x;
        for (int n = 0; n < 2; n++) begin
            v[n] = 1'b0; took[n] = 1'b0; wr[n] = 1'b0; ad[n] = '0; wd[n] = '0; req_wait[n] = 0;
        end
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (!drive_en) v[n] = 1'b0;
                else if (!v[n] || took[n]) begin
                    v[n] = ($urandom_range(0, 99) < vprob);
                    wr[n] = 1'($urandom_range(0, 1));
                    ad[n] = AW'($urandom_range(0, 15));
                    wd[n] = DW'($urandom);
                    req_wait[n] = $urandom_range(0, 6);
                end
            end
            bus.req0_valid = v[0]; bus.req0_write = wr[0]; bus.req0_addr = ad[0]; bus.req0_wdata = wd[0];
            bus.req1_valid = v[1]; bus.req1_write = wr[1]; bus.req1_addr = ad[1]; bus.req1_wdata = wd[1];
            #2;
            took[0] = bus.req0_valid && bus.req0_ready;
            took[1] = bus.req1_valid && bus.req1_ready;
            for (int n = 0; n < 2; n++) begin
                if (took[n]) begin
                    x.id    = n;
                    x.write = wr[n];
                    x.addr  = ad[n];
                    x.wdata = wd[n];
                    x.acc   = cyc;
                    x.err   = (req_wait[n] >= TO);
                    x.rdata = (x.err || x.write) ? '0 : model_mem[x.addr];
                    if (!x.err && x.write) model_mem[x.addr] = x.wdata;
                    x.due   = cyc + (x.err ? TO + 2 : 3 + req_wait[n]);
                    slave_wait = req_wait[n];
                    sb.push_back(x);
                end
            end
        end
    end

    // APB register slave: pready after slave_wait stalled ACCESS cycles, random noise elsewhere.
    initial begin
        int acc_n;
        acc_n = 0;
        forever begin
            @(negedge clk);
            if (bus.apb_psel && bus.apb_penable) begin
                acc_n++;
                if (acc_n > slave_wait) begin
                    bus.apb_pready = 1'b1;
                    bus.apb_prdata = slave_mem[bus.apb_paddr];
                    if (bus.apb_pwrite) slave_mem[bus.apb_paddr] = bus.apb_pwdata;
                end else begin
                    bus.apb_pready = 1'b0;
                    bus.apb_prdata = DW'($urandom);
                end
            end else begin
                acc_n = 0;
                bus.apb_pready = 1'($urandom_range(0, 1));
                bus.apb_prdata = DW'($urandom);
            end
        end
    end

    // Monitor: arbitration model, APB phase checks and response scoreboard.
    initial begin
        bit            mlast;
        int            mfree;
        logic [DW-1:0] lrd;
        logic          lerr;
        bit            v0, v1, idle, win, e0, e1;
        xfer_t         x;
        mlast = 1'b1; mfree = 0; lrd = '0; lerr = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                check("ready0_in_reset", bus.req0_ready, 0);
                check("ready1_in_reset", bus.req1_ready, 0);
                sb.delete();
                mlast = 1'b1; mfree = 0; lrd = '0; lerr = 1'b0;
            end
            if (rst_at_edge) begin
                check("reset_psel", bus.apb_psel, 0);
                check("reset_penable", bus.apb_penable, 0);
                check("reset_pwrite", bus.apb_pwrite, 0);
                check("reset_paddr", bus.apb_paddr, 0);
                check("reset_pwdata", bus.apb_pwdata, 0);
                check("reset_rsp0_valid", bus.rsp0_valid, 0);
                check("reset_rsp1_valid", bus.rsp1_valid, 0);
                check("reset_rsp_rdata", bus.rsp_rdata, 0);
                check("reset_rsp_err", bus.rsp_err, 0);
            end
            if (!rst) begin
                // Arbitration: bus free from the response cycle on; ties go away from last winner.
                v0 = bus.req0_valid; v1 = bus.req1_valid;
                idle = (cyc >= mfree);
                win = (v0 && v1) ? !mlast : v1;
                e0 = idle && v0 && !win;
                e1 = idle && v1 && win;
                check("req0_ready", bus.req0_ready, e0);
                check("req1_ready", bus.req1_ready, e1);
                if (e0 || e1) begin
                    mlast = win;
                    mfree = cyc + ((req_wait[win] >= TO) ? TO + 2 : 3 + req_wait[win]);
                end
                // Responses
                if (bus.rsp0_valid || bus.rsp1_valid) begin
                    check("rsp_one_owner", bus.rsp0_valid && bus.rsp1_valid, 0);
                    check("rsp_pending", sb.size() != 0, 1);
                    lrd = bus.rsp_rdata; lerr = bus.rsp_err;
                    if (sb.size() != 0) begin
                        x = sb.pop_front();
                        check("rsp_owner", bus.rsp1_valid, x.id);
                        check("rsp_cycle", cyc, x.due);
                        check("rsp_err", bus.rsp_err, x.err);
                        check("rsp_rdata", bus.rsp_rdata, x.rdata);
                        lrd = x.rdata; lerr = x.err;
                    end
                end else begin
                    check("rsp_rdata_hold", bus.rsp_rdata, lrd);
                    check("rsp_err_hold", bus.rsp_err, lerr);
                    if (sb.size() != 0 && cyc >= sb[0].due) begin
                        check("rsp_at_due", bus.rsp0_valid || bus.rsp1_valid, 1);
                        x = sb.pop_front();
                    end
                end
                // APB phases for the transfer in flight
                if (sb.size() == 0) begin
                    check("psel_idle", bus.apb_psel, 0);
                    check("penable_idle", bus.apb_penable, 0);
                end else begin
                    x = sb[0];
                    check("psel_busy", bus.apb_psel, 1);
                    check("penable_phase", bus.apb_penable, (cyc > x.acc + 1));
                    check("paddr_stable", bus.apb_paddr, x.addr);
                    check("pwrite_stable", bus.apb_pwrite, x.write);
                    check("pwdata_stable", bus.apb_pwdata, x.wdata);
                end
            end
        end
    end

    // Sequence: reset, random traffic, reset during a read ACCESS, saturated traffic, drain.
    initial begin
        bit found;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.apb_pready = 1'b0; bus.apb_prdata = '0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = DW'(i * 7 + 3);
            slave_mem[i] = DW'(i * 7 + 3);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_en = 1'b1;
        repeat (1500) @(negedge clk);

        vprob = 100;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            #3;
            if (bus.apb_psel && bus.apb_penable && !bus.apb_pwrite) found = 1'b1;
        end
        check("read_access_found", found, 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);

        drive_en = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
